// File: rtl/tthbif_pkg.sv
// tthbif_pkg: shared constants and types for the tthbif UART control block.
//   - command opcodes and response bytes
//   - register address map
//   - control FSM state encoding
//   - per-lane tap-select types
package tthbif_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] ID_VAL  = 8'hB1;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_DIV_LO    = 8'h01;
  localparam logic [7:0] ADDR_DIV_HI    = 8'h02;
  localparam logic [7:0] ADDR_ID        = 8'h03;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_LANE_BASE = 8'h10;

  // Smallest divisor the UART can run with; smaller commits are refused.
  localparam int DIV_MIN = 16;

  // ST_ADDR is entered once a valid opcode has been decoded.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_COMMIT
  } ctrl_state_e;

  typedef logic [1:0] tap_sel_t;

  // Layout of a LANE register byte (msb first).
  typedef struct packed {
    tap_sel_t tx_comb;
    tap_sel_t tx_flop;
    tap_sel_t rx_comb;
    tap_sel_t rx_flop;
  } lane_cfg_t;

  localparam lane_cfg_t LANE_RESET = lane_cfg_t'(8'hFF);

endpackage

// File: rtl/tthbif_ctrl_regs.sv
// tthbif_ctrl_regs: register storage for the tthbif control block.
//   addr_i/wdata_i  : register address and write byte
//   rd_i            : read accepted this cycle (clears STATUS when addressed)
//   wr_i            : write byte arrived; applied only if wr_ok_o
//   drop_i/timeout_i: STATUS sticky set strobes
//   commit_i        : load the active divisor from {DIV_HI, DIV_LO}
//   rdata_o/rd_ok_o : read mux value / address is readable
//   wr_ok_o         : write would be accepted; div_wr_o: write targets DIV_HI
//   en_o, clks_per_bit_o, *_sel_o: configuration outputs
module tthbif_ctrl_regs
  import tthbif_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 6875
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             addr_i,
  input  logic [7:0]             wdata_i,
  input  logic                   rd_i,
  input  logic                   wr_i,
  input  logic                   drop_i,
  input  logic                   timeout_i,
  input  logic                   commit_i,
  output logic [7:0]             rdata_o,
  output logic                   rd_ok_o,
  output logic                   wr_ok_o,
  output logic                   div_wr_o,
  output logic                   en_o,
  output logic [DIV_W-1:0]       clks_per_bit_o,
  output logic [2*NUM_LANES-1:0] rx_flop_sel_o,
  output logic [2*NUM_LANES-1:0] rx_comb_sel_o,
  output logic [2*NUM_LANES-1:0] tx_flop_sel_o,
  output logic [2*NUM_LANES-1:0] tx_comb_sel_o
);

  // DIV_HI keeps only the bits that land inside the DIV_W-wide divisor.
  localparam logic [15:0]      DIV_MASK  = (DIV_W >= 16) ? 16'hFFFF
                                         : 16'((32'd1 << DIV_W) - 32'd1);
  localparam logic [7:0]       HI_MASK   = DIV_MASK[15:8];
  localparam logic [15:0]      DIV_RST16 = 16'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);

  logic             en_q;
  logic [7:0]       lo_q;
  logic [7:0]       hi_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       stat_q;
  lane_cfg_t        lane_q [NUM_LANES];

  logic             is_lane;
  logic [3:0]       lane_idx;
  lane_cfg_t        lane_rd;
  logic [DIV_W-1:0] cand;
  logic             stat_clr;

  assign lane_idx = addr_i[3:0];
  assign is_lane  = (addr_i[7:4] == 4'h1) && (int'(addr_i[3:0]) < NUM_LANES);
  assign cand     = DIV_W'({wdata_i & HI_MASK, lo_q});
  assign div_wr_o = (addr_i == ADDR_DIV_HI);
  assign stat_clr = rd_i && (addr_i == ADDR_STATUS);

  always_comb begin
    lane_rd = lane_q[0];
    for (int n = 0; n < NUM_LANES; n++)
      if (lane_idx == 4'(n)) lane_rd = lane_q[n];
  end

  always_comb begin
    rdata_o = 8'h00;
    rd_ok_o = 1'b1;
    wr_ok_o = 1'b0;
    case (addr_i)
      ADDR_CTRL:   begin rdata_o = {7'b0, en_q};   wr_ok_o = 1'b1; end
      ADDR_DIV_LO: begin rdata_o = lo_q;           wr_ok_o = 1'b1; end
      ADDR_DIV_HI: begin rdata_o = hi_q;           wr_ok_o = (cand >= DIV_MIN_V); end
      ADDR_ID:     rdata_o = ID_VAL;
      ADDR_STATUS: rdata_o = {6'b0, stat_q};
      default: begin
        rdata_o = is_lane ? lane_rd : 8'h00;
        rd_ok_o = is_lane;
        wr_ok_o = is_lane;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      lo_q   <= DIV_RST16[7:0];
      hi_q   <= DIV_RST16[15:8] & HI_MASK;
      div_q  <= DIV_RST;
      stat_q <= 2'b00;
      for (int n = 0; n < NUM_LANES; n++) lane_q[n] <= LANE_RESET;
    end else begin
      if (wr_i && wr_ok_o) begin
        case (addr_i)
          ADDR_CTRL:   en_q <= wdata_i[0];
          ADDR_DIV_LO: lo_q <= wdata_i;
          ADDR_DIV_HI: hi_q <= wdata_i & HI_MASK;
          default:
            for (int n = 0; n < NUM_LANES; n++)
              if (lane_idx == 4'(n)) lane_q[n] <= lane_cfg_t'(wdata_i);
        endcase
      end
      // FSM is parked in COMMIT here, so {hi_q, lo_q} still holds the acked value.
      if (commit_i) div_q <= DIV_W'({hi_q, lo_q});
      // A same-cycle set survives the read-clear.
      stat_q <= (stat_q & ~{2{stat_clr}}) | {timeout_i, drop_i};
    end
  end

  assign en_o           = en_q;
  assign clks_per_bit_o = div_q;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign rx_flop_sel_o[2*n +: 2] = lane_q[n].rx_flop;
    assign rx_comb_sel_o[2*n +: 2] = lane_q[n].rx_comb;
    assign tx_flop_sel_o[2*n +: 2] = lane_q[n].tx_flop;
    assign tx_comb_sel_o[2*n +: 2] = lane_q[n].tx_comb;
  end

endmodule

// File: rtl/tthbif_ctrl.sv
// tthbif_ctrl: UART command parser and control/status registers for tthbif.
//   clk_i/rst_i          : clock, async active-high reset
//   rx_valid_i/rx_data_i : received byte strobe and data
//   tx_ready_i           : transmitter can take a byte
//   tx_valid_o/tx_data_o : registered response byte (held until accepted)
//   en_o, clks_per_bit_o : global enable, active UART divisor
//   *_sel_o              : per-lane tap selects, lane n at [2n+1:2n]
module tthbif_ctrl
  import tthbif_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int DIV_W          = 16,
  parameter int DIV_RESET      = 6875,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   tx_ready_i,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  output logic                   en_o,
  output logic [DIV_W-1:0]       clks_per_bit_o,
  output logic [2*NUM_LANES-1:0] rx_flop_sel_o,
  output logic [2*NUM_LANES-1:0] rx_comb_sel_o,
  output logic [2*NUM_LANES-1:0] tx_flop_sel_o,
  output logic [2*NUM_LANES-1:0] tx_comb_sel_o
);

  localparam int            TCW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  ctrl_state_e    state_q;
  logic           tx_valid_q;
  logic [7:0]     tx_data_q;
  logic [7:0]     addr_q;
  logic           is_wr_q;
  logic           pend_q;
  logic [TCW-1:0] tcnt_q;

  logic       waiting;
  logic       timeout;
  logic [7:0] reg_addr;
  logic       rd_acc;
  logic       wr_acc;
  logic       drop;
  logic       commit;
  logic [7:0] rdata;
  logic       rd_ok;
  logic       wr_ok;
  logic       div_wr;

  // Mid-command states where silence on the line counts toward abort.
  assign waiting  = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign timeout  = waiting && !rx_valid_i && (tcnt_q == TO_LAST);
  // The address byte is still on rx_data_i when a read is served.
  assign reg_addr = (state_q == ST_ADDR) ? rx_data_i : addr_q;
  assign rd_acc   = (state_q == ST_ADDR) && rx_valid_i && !is_wr_q;
  assign wr_acc   = (state_q == ST_DATA) && rx_valid_i;
  assign drop     = rx_valid_i && ((state_q == ST_RESP) || (state_q == ST_COMMIT));
  assign commit   = (state_q == ST_COMMIT) && tx_ready_i;

  tthbif_ctrl_regs #(
    .NUM_LANES (NUM_LANES),
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_regs (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .addr_i         (reg_addr),
    .wdata_i        (rx_data_i),
    .rd_i           (rd_acc),
    .wr_i           (wr_acc),
    .drop_i         (drop),
    .timeout_i      (timeout),
    .commit_i       (commit),
    .rdata_o        (rdata),
    .rd_ok_o        (rd_ok),
    .wr_ok_o        (wr_ok),
    .div_wr_o       (div_wr),
    .en_o           (en_o),
    .clks_per_bit_o (clks_per_bit_o),
    .rx_flop_sel_o  (rx_flop_sel_o),
    .rx_comb_sel_o  (rx_comb_sel_o),
    .tx_flop_sel_o  (tx_flop_sel_o),
    .tx_comb_sel_o  (tx_comb_sel_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      addr_q     <= 8'h00;
      is_wr_q    <= 1'b0;
      pend_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (rx_valid_i) begin
            tcnt_q  <= '0;
            is_wr_q <= (rx_data_i == OP_WR);
            if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
              state_q <= ST_ADDR;
            end else begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= RSP_NAK;
              state_q    <= ST_RESP;
            end
          end
        ST_ADDR:
          if (rx_valid_i) begin
            tcnt_q <= '0;
            addr_q <= rx_data_i;
            if (is_wr_q) begin
              state_q <= ST_DATA;
            end else begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= rd_ok ? rdata : RSP_NAK;
              state_q    <= ST_RESP;
            end
          end else if (timeout) begin
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        ST_DATA:
          if (rx_valid_i) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= wr_ok ? RSP_ACK : RSP_NAK;
            pend_q     <= wr_ok && div_wr;
            state_q    <= ST_RESP;
          end else if (timeout) begin
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        ST_RESP:
          if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            state_q    <= pend_q ? ST_COMMIT : ST_IDLE;
          end
        ST_COMMIT:
          // Divisor swaps only after the ACK is out at the old baud.
          if (tx_ready_i) begin
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

endmodule
